cla_word_sequencer: RTL and testbench

CLA_WORD_SEQUENCER -- requirements
Module: cla_word_sequencer

---
 rtl/cla_pkg.sv | 21 ++
 rtl/cla_5bit.sv | 36 +++
 rtl/cla_word_sequencer.sv | 143 ++++++++++++++
 tb/tb_cla_word_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the CLA word sequencer: slice width, FSM state type
// and the slice-index width helper.
package cla_pkg;

  localparam int SLICE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest index width able to address n slices (never below one bit).
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/cla_5bit.sv
// Single 5-bit carry-lookahead slice adder; all carries are formed directly
// from generate/propagate terms rather than rippled.
module cla_5bit
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);

  logic [SLICE_W-1:0] g_s;
  logic [SLICE_W-1:0] p_s;
  logic [SLICE_W:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  assign c_s[0] = c_in;
  assign c_s[1] = g_s[0] | (p_s[0] & c_in);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_in);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & c_in);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_in);
  assign c_s[5] = g_s[4] | (p_s[4] & g_s[3]) | (p_s[4] & p_s[3] & g_s[2])
                | (p_s[4] & p_s[3] & p_s[2] & g_s[1])
                | (p_s[4] & p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[4] & p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_in);

  assign sum   = p_s ^ c_s[SLICE_W-1:0];
  assign c_out = c_s[SLICE_W];

endmodule

// File: rtl/cla_word_sequencer.sv
// Word adder that walks NUM_SLICES 5-bit slices through one shared cla_5bit.
// Optional signed-overflow output is enabled by defining CLA_SEQ_OVF_EN.
module cla_word_sequencer
  import cla_pkg::*;
#(
  parameter  int NUM_SLICES = 4,
  localparam int W          = SLICE_W * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out
`ifdef CLA_SEQ_OVF_EN
  ,output logic        ovf
`endif
);

  localparam int              KW     = idx_w(NUM_SLICES);
  localparam logic [KW-1:0]   LAST_K = KW'(NUM_SLICES - 1);
  localparam logic [KW-1:0]   K_ONE  = KW'(1);

  state_t             state_r;
  state_t             next_state_s;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [W-1:0]       sum_r;
  logic [KW-1:0]      k_r;
  logic               carry_r;
  logic               c_out_r;
  logic [SLICE_W-1:0] slice_a_s;
  logic [SLICE_W-1:0] slice_b_s;
  logic [SLICE_W-1:0] slice_sum_s;
  logic               slice_cout_s;
  logic               last_slice_s;

  assign slice_a_s    = a_r[k_r*SLICE_W +: SLICE_W];
  assign slice_b_s    = b_r[k_r*SLICE_W +: SLICE_W];
  assign last_slice_s = (k_r == LAST_K);

  cla_5bit u_slice (
    .a     (slice_a_s),
    .b     (slice_b_s),
    .c_in  (carry_r),
    .sum   (slice_sum_s),
    .c_out (slice_cout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; handshakes only matter in their own state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) next_state_s = RUN;
        else          next_state_s = IDLE;
      end
      RUN: begin
        if (last_slice_s) next_state_s = DONE;
        else              next_state_s = RUN;
      end
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Operand capture and one slice of the sum per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      k_r     <= {KW{1'b0}};
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= c_in;
            k_r     <= {KW{1'b0}};
          end
        end
        RUN: begin
          sum_r[k_r*SLICE_W +: SLICE_W] <= slice_sum_s;
          carry_r                       <= slice_cout_s;
          if (last_slice_s) begin
            c_out_r <= slice_cout_s;
            k_r     <= {KW{1'b0}};
          end else begin
            k_r     <= k_r + K_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic ovf_r;
  logic msb_cin_s;

  // Carry into the word MSB recovered from that bit's operands and sum.
  assign msb_cin_s = slice_a_s[SLICE_W-1] ^ slice_b_s[SLICE_W-1] ^ slice_sum_s[SLICE_W-1];

  // Overflow flag captured together with the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if ((state_r == RUN) && last_slice_s) begin
      ovf_r <= msb_cin_s ^ slice_cout_s;
    end
  end

  assign ovf = ovf_r;
`endif

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign sum       = sum_r;
  assign c_out     = c_out_r;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench: directed table and corner sequences on a 4-slice DUT,
// plus randomized traffic on 2/4/8-slice DUTs against an arithmetic model.
module tb_cla_word_sequencer;

  localparam int NS  = 4;
  localparam int W   = 5 * NS;
  localparam int NTX = 1500;
  localparam int NV  = 9;

  logic         clk;
  logic         rst_n;
  logic         rnd_rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
`endif

  int n_checks;
  int n_errors;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t vecs [NV];

  cla_word_sequencer #(.NUM_SLICES(NS)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef CLA_SEQ_OVF_EN
    ,.ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed overflow: does the two's-complement result leave the w-bit range?
  function automatic logic ref_ovf(input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input int w);
    longint lim, sx, sy, s;
    lim = longint'(1) << (w - 1);
    sx  = (x >= 64'(lim)) ? longint'(x) - (lim << 1) : longint'(x);
    sy  = (y >= 64'(lim)) ? longint'(y) - (lim << 1) : longint'(y);
    s   = sx + sy + longint'(ci);
    return (s >= lim) || (s < -lim);
  endfunction

  task automatic run_word(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          input int stall, input bit noisy,
                          output logic [W-1:0] rs, output logic rc, output logic ro,
                          output int lat);
    int cnt;
    @(negedge clk);
    a = ia; b = ib; c_in = ic; in_valid = 1'b1; out_ready = noisy;
    cnt = 0;
    while (!in_ready && cnt < 20) begin @(negedge clk); cnt++; end
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    if (noisy) begin
      a = ~ia; b = ~ib; c_in = ~ic;
    end else begin
      in_valid = 1'b0;
    end
    while (!out_valid && lat < 64) begin @(negedge clk); lat++; end
    in_valid = 1'b0;
    rs = sum;
    rc = c_out;
`ifdef CLA_SEQ_OVF_EN
    ro = ovf;
`else
    ro = 1'b0;
`endif
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("accept_to_idle", in_ready, 64'd1);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int GNS = (gi == 0) ? 2 : ((gi == 1) ? 4 : 8);
    localparam int GW  = 5 * GNS;

    logic          r_in_valid, r_in_ready, r_c_in, r_out_valid, r_out_ready, r_c_out;
    logic [GW-1:0] r_a, r_b, r_sum;
`ifdef CLA_SEQ_OVF_EN
    logic          r_ovf;
`endif
    logic          done_f;

    cla_word_sequencer #(.NUM_SLICES(GNS)) u_rnd (
      .clk       (clk),
      .rst_n     (rnd_rst_n),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready),
      .a         (r_a),
      .b         (r_b),
      .c_in      (r_c_in),
      .out_valid (r_out_valid),
      .out_ready (r_out_ready),
      .sum       (r_sum),
      .c_out     (r_c_out)
`ifdef CLA_SEQ_OVF_EN
      ,.ovf      (r_ovf)
`endif
    );

    initial begin : rnd_proc
      logic [GW-1:0] xa, xb;
      logic          xc;
      logic [GW:0]   full;
      int            lat, cnt;
      done_f = 1'b0;
      r_in_valid = 1'b0; r_a = {GW{1'b0}}; r_b = {GW{1'b0}}; r_c_in = 1'b0; r_out_ready = 1'b0;
      wait (rnd_rst_n === 1'b1);
      for (int t = 0; t < NTX; t++) begin
        case ($urandom_range(7, 0))
          0:       xa = {GW{1'b1}};
          1:       xa = {GW{1'b0}};
          default: xa = GW'({$urandom(), $urandom()});
        endcase
        case ($urandom_range(7, 0))
          0:       xb = {GW{1'b1}};
          1:       xb = {GW{1'b0}};
          default: xb = GW'({$urandom(), $urandom()});
        endcase
        xc   = 1'($urandom_range(1, 0));
        full = {1'b0, xa} + {1'b0, xb} + {{GW{1'b0}}, xc};
        repeat ($urandom_range(2, 0)) @(negedge clk);
        @(negedge clk);
        r_a = xa; r_b = xb; r_c_in = xc; r_in_valid = 1'b1;
        cnt = 0;
        while (!r_in_ready && cnt < 20) begin @(negedge clk); cnt++; end
        @(posedge clk);
        @(negedge clk);
        r_in_valid = 1'($urandom_range(1, 0));
        r_a = GW'({$urandom(), $urandom()});
        r_b = GW'({$urandom(), $urandom()});
        r_c_in = 1'($urandom_range(1, 0));
        lat = 1;
        while (!r_out_valid && lat < 64) begin
          r_out_ready = 1'($urandom_range(1, 0));
          @(negedge clk);
          lat++;
        end
        r_in_valid = 1'b0;
        check($sformatf("rnd%0d_latency", GNS), 64'(lat), 64'(GNS + 1));
        check($sformatf("rnd%0d_sum", GNS), 64'(r_sum), 64'(full[GW-1:0]));
        check($sformatf("rnd%0d_c_out", GNS), 64'(r_c_out), 64'(full[GW]));
`ifdef CLA_SEQ_OVF_EN
        check($sformatf("rnd%0d_ovf", GNS), 64'(r_ovf), 64'(ref_ovf(64'(xa), 64'(xb), xc, GW)));
`endif
        cnt = 0;
        while (!r_out_ready && cnt < 32) begin
          @(negedge clk);
          cnt++;
          check($sformatf("rnd%0d_hold", GNS), 64'(r_sum), 64'(full[GW-1:0]));
          r_out_ready = 1'($urandom_range(1, 0));
        end
        r_out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("rnd%0d_idle", GNS), 64'(r_in_ready), 64'd1);
        check($sformatf("rnd%0d_ov_low", GNS), 64'(r_out_valid), 64'd0);
        r_out_ready = 1'($urandom_range(1, 0));
      end
      done_f = 1'b1;
    end
  end

  initial begin
    logic [W-1:0] rs;
    logic         rc, ro;
    int           lat, cnt;

    vecs[0] = '{20'h00001, 20'h0001F, 1'b0, 20'h00020, 1'b0, 1'b0};
    vecs[1] = '{20'hFFFFF, 20'h00000, 1'b1, 20'h00000, 1'b1, 1'b0};
    vecs[2] = '{20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1};
    vecs[3] = '{20'h12345, 20'h0ABCD, 1'b0, 20'h1CF12, 1'b0, 1'b0};
    vecs[4] = '{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1};
    vecs[5] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 1'b0};
    vecs[6] = '{20'h0F0F0, 20'hF0F0F, 1'b1, 20'h00000, 1'b1, 1'b0};
    vecs[7] = '{20'h00000, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[8] = '{20'h3E0F8, 20'h01F08, 1'b1, 20'h40001, 1'b0, 1'b0};

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; rnd_rst_n = 1'b0;
    in_valid = 1'b0; a = {W{1'b0}}; b = {W{1'b0}}; c_in = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_c_out", c_out, 64'd0);
`ifdef CLA_SEQ_OVF_EN
    check("rst_ovf", ovf, 64'd0);
`endif
    rst_n = 1'b1; rnd_rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 64'd1);

    for (int i = 0; i < NV; i++) begin
      run_word(vecs[i].va, vecs[i].vb, vecs[i].vc, i % 3, (i % 2) == 1, rs, rc, ro, lat);
      check($sformatf("vec%0d_sum", i), rs, vecs[i].es);
      check($sformatf("vec%0d_c_out", i), rc, vecs[i].ec);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NS + 1));
`ifdef CLA_SEQ_OVF_EN
      check($sformatf("vec%0d_ovf", i), ro, vecs[i].eo);
`endif
    end

    // Long stall in DONE with new operands offered every other cycle.
    @(negedge clk);
    a = 20'h12345; b = 20'h0ABCD; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin @(negedge clk); cnt++; end
    check("stall_done", out_valid, 64'd1);
    for (int i = 0; i < 10; i++) begin
      a = 20'hFFFFF ^ W'(i); b = 20'h55555; c_in = 1'b1; in_valid = ((i % 2) == 0);
      @(negedge clk);
      check("stall_sum", sum, 64'h1CF12);
      check("stall_c_out", c_out, 64'd0);
      check("stall_in_ready", in_ready, 64'd0);
      check("stall_out_valid", out_valid, 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_idle", in_ready, 64'd1);
    check("stall_release_ov", out_valid, 64'd0);

    // Reset while slice 2 is being added.
    @(negedge clk);
    a = 20'h0F0F0; b = 20'h0F0F0; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 64'd0);
    check("midrst_sum", sum, 64'd0);
    check("midrst_in_ready", in_ready, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NS + 2) @(negedge clk);
    check("midrst_no_result", out_valid, 64'd0);
    check("midrst_idle", in_ready, 64'd1);
    run_word(20'h12345, 20'h0ABCD, 1'b0, 0, 1'b0, rs, rc, ro, lat);
    check("postrst_sum", rs, 64'h1CF12);
    check("postrst_c_out", rc, 64'd0);

    cnt = 0;
    while (!(g_rnd[0].done_f && g_rnd[1].done_f && g_rnd[2].done_f) && cnt < 80000) begin
      @(negedge clk);
      cnt++;
    end
    check("random_complete", 64'(g_rnd[0].done_f && g_rnd[1].done_f && g_rnd[2].done_f), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
